// File: rtl/signed_sat_pkg.sv
// Shared types and constants for the signed saturating frame accumulator.
// Optional feature macro used by the block: SIGNED_SAT_ACC_SAT_FLAG_EN (adds out_sat).
package signed_sat_pkg;

    // ACC collects samples, OUT holds a finished frame result.
    typedef enum logic {StAcc, StOut} state_e;

    // Largest two's-complement value representable in 'width' bits.
    function automatic longint sat_max(input int unsigned width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction

    // Smallest two's-complement value representable in 'width' bits.
    function automatic longint sat_min(input int unsigned width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/signed_sat_accumulator_if.sv
// Sample-in / result-out handshake bundle for signed_sat_accumulator.
// out_sat exists only when SIGNED_SAT_ACC_SAT_FLAG_EN is defined.
interface signed_sat_accumulator_if #(
    parameter int unsigned W     = 4,
    parameter int unsigned ACC_W = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
`ifdef SIGNED_SAT_ACC_SAT_FLAG_EN
    logic                    out_sat;

    // Master drives samples and consumes results; slave is the accumulator.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/signed_sat_accumulator_sat_add.sv
// Combinational ACC_W-bit signed adder that clamps to the representable range.
// Overflow: both operands share a sign and the raw sum's sign differs from it.
module sat_add
    import signed_sat_pkg::*;
#(
    parameter int unsigned ACC_W = 5
) (
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W-1:0] b_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    ovf_o
);
    localparam logic signed [ACC_W-1:0] MaxVal = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MinVal = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W-1:0] raw;

    // Wrapping sum, overflow detect and clamp toward the operands' sign.
    always_comb begin
        raw   = a_i + b_i;
        ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]);
        sum_o = raw;
        if (ovf_o) begin
            sum_o = a_i[ACC_W-1] ? MinVal : MaxVal;
        end
    end
endmodule

// File: rtl/signed_sat_accumulator.sv
// Accumulates N signed samples per frame with saturation, then holds the frame
// sum until the downstream handshake. Define SIGNED_SAT_ACC_SAT_FLAG_EN to add
// the sticky per-frame saturation flag out_sat.
module signed_sat_accumulator
    import signed_sat_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned ACC_W = 5,
    parameter int unsigned N     = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    signed_sat_accumulator_if.slave sat_io
);
    localparam int unsigned       CntW    = $clog2(N + 1);
    localparam logic [CntW-1:0]   LastCnt = CntW'(N - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic signed [W-1:0]     samp;
    logic signed [ACC_W-1:0] samp_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    ovf;
    logic                    accept;
    logic                    release_res;

    assign samp        = sat_io.in_data;
    assign samp_ext    = ACC_W'(samp);
    assign accept      = sat_io.in_valid && (state_q == StAcc);
    assign release_res = sat_io.out_ready && (state_q == StOut);

    // in_ready depends on state only, so out_ready never reaches it combinationally.
    assign sat_io.in_ready  = (state_q == StAcc);
    assign sat_io.out_valid = (state_q == StOut);
    // acc_q is frozen in OUT, so it doubles as the held result.
    assign sat_io.out_data  = acc_q;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a_i   (acc_q),
        .b_i   (samp_ext),
        .sum_o (sum),
        .ovf_o (ovf)
    );

    // Next-state: accumulate in ACC, clear everything when the result is taken.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StAcc: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (release_res) begin
                    state_d = StAcc;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    // State, accumulator and sample count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SIGNED_SAT_ACC_SAT_FLAG_EN
    logic sat_q, sat_d;

    // Sticky over a frame; cleared as the held result is released.
    always_comb begin
        sat_d = sat_q;
        if (accept && ovf) begin
            sat_d = 1'b1;
        end
        if (release_res) begin
            sat_d = 1'b0;
        end
    end

    // Saturation flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_io.out_sat = sat_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif
endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Self-checking bench for signed_sat_accumulator (W=4, ACC_W=5, N=4).
// Directed frames plus a randomly gated run against an integer reference model.
module tb_signed_sat_accumulator;
    localparam int W     = 4;
    localparam int ACC_W = 5;
    localparam int N     = 4;
    localparam int AMAX  = (1 << (ACC_W - 1)) - 1;
    localparam int AMIN  = -(1 << (ACC_W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    signed_sat_accumulator_if #(.W(W), .ACC_W(ACC_W)) bus ();

    signed_sat_accumulator #(
        .W     (W),
        .ACC_W (ACC_W),
        .N     (N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sat_io (bus)
    );

    always #5 clk = ~clk;

    // Reference: add in unbounded integers, then clamp to the accumulator range.
    function automatic int sat_step(input int acc, input int s);
        int r;
        r = acc + s;
        if (r > AMAX) r = AMAX;
        if (r < AMIN) r = AMIN;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and wait (bounded) until it is taken.
    task automatic send_sample(input int v);
        int waits;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(v);
        while (!bus.in_ready && waits < 100) begin
            step();
            waits++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%0d required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
`ifdef SIGNED_SAT_ACC_SAT_FLAG_EN
        checks++;
        if (bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat: out_sat=%b required 0", bus.out_sat);
        end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_sample(3);
        send_sample(-2);
        send_sample(5);
        send_sample(-1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 5'sd5 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame: out_valid=%b out_data=%0d in_ready=%b required 1 5 0",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
`ifdef SIGNED_SAT_ACC_SAT_FLAG_EN
        checks++;
        if (bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_sat: out_sat=%b required 0", bus.out_sat);
        end
`endif
        take_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b required 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    // One frame of four samples, then compare value and optional flag.
    task automatic test_saturation_frame(input int s0, input int s1, input int s2,
                                         input int s3, input int exp_sum, input bit exp_sat);
        send_sample(s0);
        send_sample(s1);
        send_sample(s2);
        send_sample(s3);
        checks++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_data) !== exp_sum) begin
            errors++;
            $display("FAIL sat_frame %0d,%0d,%0d,%0d: out_valid=%b out_data=%0d required 1 %0d",
                     s0, s1, s2, s3, bus.out_valid, bus.out_data, exp_sum);
        end
`ifdef SIGNED_SAT_ACC_SAT_FLAG_EN
        checks++;
        if (bus.out_sat !== exp_sat) begin
            errors++;
            $display("FAIL sat_flag: out_sat=%b required %b", bus.out_sat, exp_sat);
        end
`else
        if (exp_sat) begin end
`endif
        take_result();
    endtask

    task automatic test_backpressure();
        send_sample(2);
        send_sample(2);
        send_sample(2);
        send_sample(2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(7);
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 5'sd8 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: out_valid=%b out_data=%0d in_ready=%b required 1 8 0",
                         i, bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        take_result();
        // Samples offered while holding must not have leaked into this frame.
        test_saturation_frame(1, 1, 1, 1, 4, 1'b0);
    endtask

    task automatic test_reset_midframe();
        send_sample(5);
        send_sample(6);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b out_data=%0d required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.out_data);
        end
        step();
        rst_n = 1'b1;
        test_saturation_frame(1, 1, 1, 1, 4, 1'b0);
        // Reset while a result is held also discards it.
        send_sample(7);
        send_sample(7);
        send_sample(7);
        send_sample(7);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: out_valid=%b required 0", bus.out_valid);
        end
        step();
        rst_n = 1'b1;
        test_saturation_frame(-1, 2, -3, 1, -1, 1'b0);
    endtask

    task automatic test_random();
        int exp_q[$];
        int acc_m, cnt_m, got, cyc, seen, samp_v, e;
        bit acc_ok, hs;
        acc_m = 0;
        cnt_m = 0;
        got   = 0;
        cyc   = 0;
        while (got < 100 && cyc < 20000) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = W'($urandom_range(0, (1 << W) - 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            acc_ok = bus.in_valid && bus.in_ready;
            hs     = bus.out_valid && bus.out_ready;
            seen   = int'(bus.out_data);
            samp_v = int'(bus.in_data);
            step();
            cyc++;
            if (acc_ok) begin
                acc_m = sat_step(acc_m, samp_v);
                cnt_m++;
                if (cnt_m == N) begin
                    exp_q.push_back(acc_m);
                    acc_m = 0;
                    cnt_m = 0;
                end
            end
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: got result %0d with no complete frame", seen);
                end else begin
                    e = exp_q.pop_front();
                    if (seen !== e) begin
                        errors++;
                        $display("FAIL rand_frame%0d: out_data=%0d required %0d", got, seen, e);
                    end
                end
                got++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (got != 100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: results=%0d pending=%0d required 100 0", got, exp_q.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation_frame(7, 7, 7, 7, 15, 1'b1);
        test_saturation_frame(-8, -8, -8, -8, -16, 1'b1);
        test_saturation_frame(7, 7, 7, -8, 7, 1'b1);
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/signed_sat_accumulator.md
SIGNED_SAT_ACCUMULATOR -- requirements
Module: signed_sat_accumulator

Interface
- REQ-001: Parameter W, default 4: signed input sample width in bits.
- REQ-002: Parameter ACC_W, default 5: signed accumulator and result width in bits; legal only if ACC_W >= W.
- REQ-003: Parameter N, default 4: samples per frame; legal only if N >= 1.
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-006: in_valid  input  1  upstream sample valid.
- REQ-007: in_ready  output  1  block accepts a sample this cycle.
- REQ-008: in_data  input  W  signed two's-complement sample, typically the upstream saturating adder's sum.
- REQ-009: out_valid  output  1  frame result available.
- REQ-010: out_ready  input  1  downstream accepts the result.
- REQ-011: out_data  output  ACC_W  signed saturated frame sum.
- REQ-012: out_sat  output  1  sticky saturation flag for the frame; present only when SIGNED_SAT_ACC_SAT_FLAG_EN is defined.

Function
- REQ-013: The block SHALL implement two states, ACC (collecting) and OUT (holding a result).
- REQ-014: In ACC, in_ready SHALL be 1; in OUT, in_ready SHALL be 0, with no combinational path from out_ready to in_ready.
- REQ-015: A sample is accepted when in_valid and in_ready are both 1; on accept, acc SHALL become sat_add(acc, sign-extended in_data) and the count SHALL increment.
- REQ-016: sat_add SHALL clamp to 2^(ACC_W-1)-1 on positive overflow and to -2^(ACC_W-1) on negative overflow; the clamped value SHALL be the operand for the next add, not a sticky saturated state.
- REQ-017: On accepting sample N of a frame, the state SHALL move to OUT; out_valid SHALL be 1 in the cycle after that accept, with out_data equal to the final acc.
- REQ-018: In OUT, out_valid and out_data SHALL remain stable until out_ready is 1.
- REQ-019: On out_ready with out_valid, the block SHALL return to ACC in the next cycle with acc=0 and count=0; out_valid SHALL fall in that cycle.
- REQ-020: Cycles with in_valid=0 in ACC SHALL leave acc and the count unchanged.
- REQ-021: With N=1, each accepted sample SHALL be emitted sign-extended, with no saturation.
- REQ-022: The count SHALL be ceil(log2(N+1)) bits wide and SHALL never exceed N.

Reset
- REQ-023: When rst_n=0, the block SHALL immediately set state=ACC, acc=0, count=0, out_valid=0, out_data=0, and out_sat=0 if present.
- REQ-024: A reset during a partial frame or a held result SHALL discard it; the first frame after reset SHALL start from zero.

Configuration
- REQ-025: With SIGNED_SAT_ACC_SAT_FLAG_EN defined, out_sat SHALL be set by any clamping add in the current frame, held with out_data, and cleared when the next frame starts.
- REQ-026: Without SIGNED_SAT_ACC_SAT_FLAG_EN, the out_sat port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
- REQ-027: The package signed_sat_pkg SHALL hold the state enum (ACC, OUT) and functions returning the max and min signed constants for a given width.
- REQ-028: Saturating addition SHALL be a combinational sub-module, sat_add (ACC_W-bit a, b, sum, ovf), which detects overflow from equal operand signs and a differing result sign.

Verification (defaults W=4, ACC_W=5, N=4)
- REQ-029: Samples 3, -2, 5, -1 back-to-back -> out_valid one cycle after the fourth accept, out_data=5, out_sat=0.
- REQ-030: Samples 7, 7, 7, 7 -> out_data=15, out_sat=1; samples -8, -8, -8, -8 -> out_data=-16, out_sat=1.
- REQ-031: Samples 7, 7, 7, -8 -> partial sums 7, 14, 15 (clamped), then final 7; out_sat=1.
- REQ-032: Hold out_ready=0 for 3 cycles after out_valid -> out_data stays stable and in_ready=0 throughout; the next frame is accepted only after the out handshake.
- REQ-033: Assert rst_n=0 after two accepts, then feed 1, 1, 1, 1 -> out_data=4, with no contribution from the pre-reset samples.
- REQ-034: Randomly gate in_valid and out_ready over 100 frames -> every out_data matches a saturating reference model, with no lost or duplicated samples.
